stage4_decode_queue: RTL and testbench

Circular FIFO between the decode stage and the execute stage of the four-stage pipeline, buffering decoded instruction bundles so decode can run ahead of a stalled or multi-cycle execute. It accepts bundles on `queue_wen` from decode and presents the oldest bundle to execute. The hazard unit holds it with `stall_queue` and clears it with `flush_queue`; it reports back-pressure to the hazard unit and decode through `is_queue_full`.

---
 rtl/stage4_decode_queue_if.sv | 48 ++++
 rtl/stage4_decode_queue.sv | 80 ++++++++
 tb/tb_stage4_decode_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage4_decode_queue_if.sv
// ---------------------------------------------------------------------------
// stage4_decode_queue_if
//
// Bundle of the signals between decode, execute, the hazard unit and the
// decode-to-execute queue.
//
// Handshake semantics:
//   push: decode raises queue_wen with wdata. The bundle is accepted at the
//         rising edge only if is_queue_full was low and flush_queue is low in
//         that cycle. Otherwise it is dropped, and decode is expected to hold
//         off while is_queue_full is high.
//   pop:  valid_out high means rdata holds the oldest bundle. Execute raises
//         deq to consume it. The pop happens at the rising edge when
//         valid_out=1, stall_queue=0 and flush_queue=0. deq while valid_out=0
//         is ignored.
//   flush_queue discards every entry and wins over push and pop in the same
//   cycle.
//
// Modports:
//   master - decode / execute / hazard side (drives the controls, reads status)
//   slave  - the queue itself
// ---------------------------------------------------------------------------
interface stage4_decode_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  queue_wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  deq;
  logic                  stall_queue;
  logic                  flush_queue;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  valid_out;
  logic                  is_queue_full;
  logic [CW-1:0]         count;

  modport master (
    output queue_wen, wdata, deq, stall_queue, flush_queue,
    input  rdata, valid_out, is_queue_full, count
  );

  modport slave (
    input  queue_wen, wdata, deq, stall_queue, flush_queue,
    output rdata, valid_out, is_queue_full, count
  );
endinterface

// File: rtl/stage4_decode_queue.sv
// ---------------------------------------------------------------------------
// stage4_decode_queue
//
// Circular FIFO that sits between decode and execute. It lets decode run
// ahead while execute is stalled or busy on a multi-cycle operation.
//
// Ports:
//   CLK  - pipeline clock; all state changes on the rising edge
//   nRST - asynchronous, active-low reset
//   q    - stage4_decode_queue_if.slave, which carries:
//          inputs:  queue_wen, wdata, deq, stall_queue, flush_queue
//          outputs: rdata, valid_out, is_queue_full, count
//
// Every output is a function of registered state only. There is no
// combinational path from any input to any output, and no bypass from wdata
// to rdata.
// ---------------------------------------------------------------------------
module stage4_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128
) (
  input logic                 CLK,
  input logic                 nRST,
  stage4_decode_queue_if.slave q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptr;
  logic [CW-1:0]         count_r;

  logic valid;
  logic full;
  logic push;
  logic pop;

  assign valid = (count_r != '0);
  assign full  = (count_r == CW'(DEPTH));

  // Push is qualified with the full flag from the start of the cycle. A pop in
  // the same cycle therefore does not make room for it: decode already sees
  // is_queue_full and is expected to retry.
  assign pop  = q.deq & ~q.stall_queue & valid & ~q.flush_queue;
  assign push = q.queue_wen & ~full & ~q.flush_queue;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr    <= '0;
      wptr    <= '0;
      count_r <= '0;
    end else if (q.flush_queue) begin
      rptr    <= '0;
      wptr    <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // The storage array needs no reset. An entry is only visible after a push
  // has written it.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= q.wdata;
  end

  assign q.valid_out     = valid;
  assign q.is_queue_full = full;
  assign q.count         = count_r;
  assign q.rdata         = valid ? mem[rptr] : '0;
endmodule

// File: tb/tb_stage4_decode_queue.sv
module tb_stage4_decode_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 128;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage4_decode_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  stage4_decode_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .q    (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks;
  int failures;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour written directly from the queue rules.
  // Full and empty are judged on the occupancy at the start of the cycle.
  task automatic model_step(input logic wen, input logic [DW-1:0] wd,
                            input logic dq, input logic st, input logic fl);
    int  size_before;
    logic do_pop;
    logic do_push;
    size_before = exp_q.size();
    if (fl) begin
      exp_q.delete();
    end else begin
      do_pop  = dq && !st && (size_before > 0);
      do_push = wen && (size_before < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(wd);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] exp_rd;
    exp_rd = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".count"}, DW'(bus.count),         DW'(exp_q.size()));
    check({tag, ".valid"}, DW'(bus.valid_out),     DW'(exp_q.size() != 0));
    check({tag, ".full"},  DW'(bus.is_queue_full), DW'(exp_q.size() == DEPTH));
    check({tag, ".rdata"}, bus.rdata,              exp_rd);
  endtask

  // ---------------- driver ----------------
  task automatic set_inputs(input logic wen, input logic [DW-1:0] wd,
                            input logic dq, input logic st, input logic fl);
    bus.queue_wen   = wen;
    bus.wdata       = wd;
    bus.deq         = dq;
    bus.stall_queue = st;
    bus.flush_queue = fl;
  endtask

  // Apply the inputs for one cycle, then return 1 time unit after the edge.
  task automatic drive_cycle(input logic wen, input logic [DW-1:0] wd,
                             input logic dq, input logic st, input logic fl);
    set_inputs(wen, wd, dq, st, fl);
    model_step(wen, wd, dq, st, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wen;
    logic [DW-1:0] wd;
    logic          dq;
    logic          st;
    logic          fl;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic          exp_full;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam logic [DW-1:0] VA = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [DW-1:0] VB = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
  localparam logic [DW-1:0] VC = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
  localparam logic [DW-1:0] VD = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;
  localparam logic [DW-1:0] VE = 128'hEEEE_0000_0000_0000_0000_0000_0000_000E;
  localparam logic [DW-1:0] VF = 128'hFFFF_0000_0000_0000_0000_0000_0000_000F;
  localparam logic [DW-1:0] VG = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  vec_t vecs[15];

  initial begin
    logic [DW-1:0] hs [4];

    checks   = 0;
    failures = 0;

    // Fill to full, drop E, pop with a dropped push, drain, deq on empty,
    // then a push followed by a push+pop.
    vecs[0]  = '{1'b1, VA, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, VA};
    vecs[1]  = '{1'b1, VB, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, VA};
    vecs[2]  = '{1'b1, VC, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, VA};
    vecs[3]  = '{1'b1, VD, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, VA};
    vecs[4]  = '{1'b1, VE, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, VA};
    vecs[5]  = '{1'b1, VE, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, VB};
    vecs[6]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, VC};
    vecs[7]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, VD};
    vecs[8]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0};
    vecs[9]  = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0};
    vecs[10] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0};
    vecs[11] = '{1'b1, VF, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, VF};
    vecs[12] = '{1'b1, VG, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, VG};
    vecs[13] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, VG};
    vecs[14] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    set_inputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.count", DW'(bus.count),         '0);
    check("reset.valid", DW'(bus.valid_out),     '0);
    check("reset.full",  DW'(bus.is_queue_full), '0);
    check("reset.rdata", bus.rdata,              '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();

    // ---------------- table ----------------
    for (int i = 0; i < 15; i++) begin
      drive_cycle(vecs[i].wen, vecs[i].wd, vecs[i].dq, vecs[i].st, vecs[i].fl);
      check($sformatf("vec%0d.count", i), DW'(bus.count),         DW'(vecs[i].exp_count));
      check($sformatf("vec%0d.valid", i), DW'(bus.valid_out),     DW'(vecs[i].exp_valid));
      check($sformatf("vec%0d.full", i),  DW'(bus.is_queue_full), DW'(vecs[i].exp_full));
      check($sformatf("vec%0d.rdata", i), bus.rdata,              vecs[i].exp_rdata);
    end

    // ---------------- streaming push+pop across pointer wrap ----------------
    drive_cycle(1'b1, DW'(0), 1'b0, 1'b0, 1'b0);
    check("stream.pre.rdata", bus.rdata, DW'(0));
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      check($sformatf("stream%0d.count", i), DW'(bus.count), DW'(1));
      check($sformatf("stream%0d.rdata", i), bus.rdata,      DW'(i));
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_model("stream.drain");

    // ---------------- stall blocks pop, push continues ----------------
    for (int i = 0; i < 4; i++) hs[i] = {$urandom, $urandom, $urandom, $urandom};
    drive_cycle(1'b1, hs[0], 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, hs[1], 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, hs[2], 1'b1, 1'b1, 1'b0);
    check("stall1.rdata", bus.rdata, hs[0]);
    check("stall1.count", DW'(bus.count), DW'(3));
    drive_cycle(1'b1, hs[3], 1'b1, 1'b1, 1'b0);
    check("stall2.rdata", bus.rdata, hs[0]);
    check("stall2.full", DW'(bus.is_queue_full), DW'(1));
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("stall3.count", DW'(bus.count), DW'(4));
    check("stall3.rdata", bus.rdata, hs[0]);
    for (int i = 1; i < 4; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check($sformatf("unstall%0d.rdata", i), bus.rdata, hs[i]);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_model("unstall.empty");

    // ---------------- flush overrides push and pop ----------------
    drive_cycle(1'b1, VA, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, VB, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, VC, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, VD, 1'b1, 1'b0, 1'b1);
    check("flush.count", DW'(bus.count),     '0);
    check("flush.valid", DW'(bus.valid_out), '0);
    check("flush.rdata", bus.rdata,          '0);
    drive_cycle(1'b1, VE, 1'b0, 1'b0, 1'b0);
    check("postflush.rdata", bus.rdata, VE);
    check("postflush.count", DW'(bus.count), DW'(1));

    // ---------------- asynchronous reset mid-cycle ----------------
    drive_cycle(1'b1, VA, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, VB, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, VC, 1'b0, 1'b0, 1'b0);
    check("prereset.full", DW'(bus.is_queue_full), DW'(1));
    set_inputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("areset.count", DW'(bus.count),         '0);
    check("areset.valid", DW'(bus.valid_out),     '0);
    check("areset.full",  DW'(bus.is_queue_full), '0);
    check("areset.rdata", bus.rdata,              '0);
    #2 rst_n = 1'b1;
    model_clear();
    drive_cycle(1'b1, VF, 1'b0, 1'b0, 1'b0);
    check("afterreset.rdata", bus.rdata, VF);
    check_model("afterreset");
    idle();

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 400; i++) begin
      logic          wen;
      logic          dq;
      logic          st;
      logic          fl;
      logic [DW-1:0] wd;
      wen = ($urandom_range(0, 99) < 60);
      dq  = ($urandom_range(0, 99) < 55);
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 3);
      wd  = {$urandom, $urandom, $urandom, $urandom};
      drive_cycle(wen, wd, dq, st, fl);
      check_model($sformatf("rand%0d", i));
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
